// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler: per-channel state
// encoding, channel-count ceiling and the cfg_ch index width helper.
package tick_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    localparam int MAX_CH = 16;

    // A single channel still needs a one-bit index port.
    function automatic int ch_index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: period/mode registers, cycle counter and registered
// tick/busy/done outputs. The sync input realigns a running channel's phase.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    input  logic             sync,
    output logic             idle,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    ch_state_t        state;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic             oneshot;
    logic             terminal;

    assign idle = (state == IDLE);

    // Terminal count only fires when nothing else (stop, retrigger, phase
    // alignment) claims the channel in the same cycle.
    assign terminal = (state == RUN) && (count == period - CNT_W'(1))
                      && !stop && !start && !sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            period  <= CNT_W'(1);
            oneshot <= 1'b0;
            count   <= '0;
            tick    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tick <= terminal;
            done <= terminal && oneshot;
            busy <= (state == RUN);

            if (cfg_we) begin
                period  <= (cfg_period == '0) ? CNT_W'(1) : cfg_period;
                oneshot <= cfg_oneshot;
            end

            if (stop) begin
                state <= IDLE;
                count <= '0;
            end else if (start) begin
                state <= RUN;
                count <= '0;
            end else if (state == RUN) begin
                if (sync) begin
                    count <= '0;
                end else if (terminal) begin
                    count <= '0;
                    if (oneshot) begin
                        state <= IDLE;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: decodes configuration writes onto NUM_CH
// independent tick_channel instances. TICK_SCHED_SYNC_EN adds the sync_all port.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = ch_index_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
`ifdef TICK_SCHED_SYNC_EN
    input  logic              sync_all,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    logic [NUM_CH-1:0]    ch_idle;
    logic [2**CH_W-1:0]   idle_pad;
    logic                 in_range;
    logic                 sync_int;

`ifdef TICK_SCHED_SYNC_EN
    assign sync_int = sync_all;
`else
    assign sync_int = 1'b0;
`endif

    // Pad the idle vector so any cfg_ch encoding indexes a defined bit;
    // unimplemented channel numbers read as not-idle and are also range-gated.
    always_comb begin
        idle_pad               = '0;
        idle_pad[NUM_CH-1:0]   = ch_idle;
    end

    assign in_range  = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign cfg_ready = in_range && idle_pad[cfg_ch];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .cfg_we     (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))),
            .cfg_period (cfg_period),
            .cfg_oneshot(cfg_oneshot),
            .start      (start[i]),
            .stop       (stop[i]),
            .sync       (sync_int),
            .idle       (ch_idle[i]),
            .tick       (tick[i]),
            .busy       (busy[i]),
            .done       (done[i])
        );
    end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent tick channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of period register and counter per channel.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  input  1  configuration write request.
REQ-006 SHALL have port cfg_ready  output  1  configuration write can be accepted this cycle.
REQ-007 SHALL have port cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-008 SHALL have port cfg_period  input  CNT_W  tick period in cycles.
REQ-009 SHALL have port cfg_oneshot  input  1  1 = one-shot mode, 0 = periodic.
REQ-010 SHALL have port start  input  NUM_CH  per-channel start/retrigger strobe.
REQ-011 SHALL have port stop  input  NUM_CH  per-channel stop strobe.
REQ-012 SHALL have port tick  output  NUM_CH  one-cycle enable pulse per channel.
REQ-013 SHALL have port busy  output  NUM_CH  channel in RUN state.
REQ-014 SHALL have port done  output  NUM_CH  one-cycle pulse when a one-shot channel completes.

Function
REQ-015 Each channel SHALL hold state IDLE or RUN, a period register, a mode bit and a CNT_W counter.
REQ-016 cfg_ready SHALL be combinational: 1 when channel cfg_ch is IDLE and cfg_ch < NUM_CH, else 0.
REQ-017 Write SHALL occur on cycle with cfg_valid && cfg_ready; period and mode latched at that edge.
REQ-018 Latched period 0 SHALL be stored as 1.
REQ-019 start[i] in IDLE SHALL clear counter and enter RUN; start sampled at cycle t gives first tick[i] at cycle t+P.
REQ-020 In RUN, counter SHALL increment each cycle; when counter == P-1, tick[i]=1 that cycle and counter wraps to 0.
REQ-021 P=1 SHALL give tick[i] every cycle from t+1.
REQ-022 Periodic mode SHALL remain in RUN after tick; one-shot mode SHALL return to IDLE at the tick edge, with done[i]=1 in the tick cycle.
REQ-023 start[i] while RUN SHALL retrigger: counter to 0, next tick P cycles later; no tick in the retrigger cycle.
REQ-024 stop[i] SHALL force IDLE next edge, suppress tick[i]/done[i] that cycle; stop wins over simultaneous start and terminal count.
REQ-025 Counter SHALL wrap only via terminal count; no CNT_W overflow possible since P <= 2^CNT_W-1.
REQ-026 cfg write and start to same channel in same cycle SHALL latch config and start with new period.
REQ-027 Channels SHALL be fully independent; any combination of ticks may assert in one cycle.
REQ-028 tick, busy, done SHALL be registered outputs.

Reset
REQ-029 reset SHALL set all channels IDLE, counters 0, periods 1, mode periodic.
REQ-030 During reset cycle tick, busy, done SHALL be 0; reset mid-RUN aborts without done.
REQ-031 reset SHALL take priority over cfg, start and stop.

Configuration
REQ-032 Macro TICK_SCHED_SYNC_EN SHALL add input port sync_all (1 bit).
REQ-033 With TICK_SCHED_SYNC_EN defined, sync_all=1 SHALL clear counters of all RUN channels that edge (phase alignment), no tick that cycle; IDLE channels unaffected; stop still wins.
REQ-034 Without TICK_SCHED_SYNC_EN, sync_all port SHALL be absent and behaviour per REQ-015..031 only.

Structure
REQ-035 Package tick_sched_pkg SHALL hold ch_state_t enum (IDLE, RUN) and MAX_CH constant (16).
REQ-036 Sub-module tick_channel SHALL implement one channel (state, period, mode, counter, tick/done); top instantiates NUM_CH copies and decodes cfg.

Verification
REQ-037 Reset then cfg ch0 P=5 periodic, start[0] at cycle 10 -> tick[0] at 15,20,25; busy[0]=1 from 11.
REQ-038 cfg ch1 P=3 one-shot, start at 20 -> tick[1] and done[1] at 23, busy[1]=0 from 24, no further ticks.
REQ-039 ch0 running P=5, cfg_valid to ch0 -> cfg_ready=0, period unchanged; stop[0] at tick cycle -> no tick, busy 0 next.
REQ-040 cfg P=0 then start at 40 -> tick every cycle from 41; start at 45 while RUN -> no tick at 45, tick at 46.
REQ-041 start and stop same cycle on IDLE ch2 -> ch2 stays IDLE; reset during RUN -> all outputs 0, no done.
REQ-042 With TICK_SCHED_SYNC_EN, ch0 P=4 and ch1 P=6 running, sync_all at 50 -> ticks at 54 and 56.
